// File: rtl/execute_stage_pkg.sv
// Shared EX-stage definitions: ALU opcodes, branch conditions, multiplier states, control bundle.
// Optional iterative multiplier is enabled with the MULT_EN macro.
package execute_stage_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_XOR  = 4'h2;
  localparam logic [3:0] ALU_ANDN = 4'h3;
  localparam logic [3:0] ALU_ROL  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_ROR  = 4'h6;
  localparam logic [3:0] ALU_SRL  = 4'h7;
  localparam logic [3:0] ALU_SEQ  = 4'h8;
  localparam logic [3:0] ALU_SLT  = 4'h9;
  localparam logic [3:0] ALU_SLE  = 4'hA;
  localparam logic [3:0] ALU_SCO  = 4'hB;
  localparam logic [3:0] ALU_BTR  = 4'hC;
  localparam logic [3:0] ALU_LBI  = 4'hD;
  localparam logic [3:0] ALU_SLBI = 4'hE;
  localparam logic [3:0] ALU_MUL  = 4'hF;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQZ = 3'b001,
    BR_BNEZ = 3'b010,
    BR_BLTZ = 3'b011,
    BR_BGEZ = 3'b100,
    BR_JMP  = 3'b101
  } brCond_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mulState_e;

  typedef struct packed {
    logic takeBranch;
    logic memWrite;
    logic memRead;
    logic regWrite;
    logic memtoReg;
    logic dump;
    logic halt;
  } exCtrl_t;

  // Loads in EX/MEM are not forwardable from there; they arrive later through MEM/WB.
  function automatic logic [15:0] fwdOperand(
    input logic [2:0]  rs,
    input logic [15:0] idexVal,
    input logic        exmemEn,
    input logic [2:0]  exmemRd,
    input logic [15:0] exmemVal,
    input logic        wbEn,
    input logic [2:0]  wbRd,
    input logic [15:0] wbVal
  );
    if (exmemEn && exmemRd == rs)  return exmemVal;
    else if (wbEn && wbRd == rs)   return wbVal;
    else                           return idexVal;
  endfunction

endpackage

// File: rtl/execute_stage_alu16.sv
// Combinational 16-bit ALU; MUL yields 0 here and is supplied by the iterative unit when present.
module alu16
  import execute_stage_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [3:0]  op,
  output logic [15:0] result
);

  logic [3:0]  sh;
  logic [16:0] sum;
  logic [15:0] rev;

  always_comb begin
    sh  = b[3:0];
    sum = {1'b0, a} + {1'b0, b};
    rev = '0;
    for (int i = 0; i < 16; i++) rev[i] = a[15-i];
    result = '0;
    case (op)
      ALU_ADD:  result = sum[15:0];
      ALU_SUB:  result = a - b;
      ALU_XOR:  result = a ^ b;
      ALU_ANDN: result = a & ~b;
      // Shifting by 16 yields 0, so sh==0 degenerates cleanly to a plain pass-through.
      ALU_ROL:  result = (a << sh) | (a >> (5'd16 - {1'b0, sh}));
      ALU_SLL:  result = a << sh;
      ALU_ROR:  result = (a >> sh) | (a << (5'd16 - {1'b0, sh}));
      ALU_SRL:  result = a >> sh;
      ALU_SEQ:  result = {15'd0, a == b};
      ALU_SLT:  result = {15'd0, $signed(a) <  $signed(b)};
      ALU_SLE:  result = {15'd0, $signed(a) <= $signed(b)};
      ALU_SCO:  result = {15'd0, sum[16]};
      ALU_BTR:  result = rev;
      ALU_LBI:  result = b;
      ALU_SLBI: result = {a[7:0], b[7:0]};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, ALU, branch resolution and EX/MEM pipeline register.
// Define MULT_EN to build the iterative shift-add multiplier that stalls the front end.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int MUL_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic [15:0] Rd1_IDEX,
  input  logic [15:0] Rd2_IDEX,
  input  logic [2:0]  Rs1_IDEX,
  input  logic [2:0]  Rs2_IDEX,
  input  logic [15:0] Imm_IDEX,
  input  logic [15:0] PCp2_IDEX,
  input  logic [3:0]  ALUOp_IDEX,
  input  logic        ALUSrc_IDEX,
  input  logic [2:0]  BrCond_IDEX,
  input  logic        MemWrite_IDEX,
  input  logic        MemRead_IDEX,
  input  logic        RegWrite_IDEX,
  input  logic        MemtoReg_IDEX,
  input  logic        Dump_IDEX,
  input  logic        halt_IDEX,
  input  logic [2:0]  WrR_IDEX,
  input  logic [15:0] WrData_WB,
  input  logic [2:0]  WrR_MEMWB,
  input  logic        RegWrite_MEMWB,
  output logic        takeBranch,
  output logic [15:0] branchTarget,
  output logic        exStall,
  output logic [15:0] ALUO_EXMEM,
  output logic [15:0] Rd2_EXMEM,
  output logic        takeBranch_EXMEM,
  output logic        MemWrite_EXMEM,
  output logic        MemRead_EXMEM,
  output logic        RegWrite_EXMEM,
  output logic        MemtoReg_EXMEM,
  output logic        Dump_EXMEM,
  output logic        halt_EXMEM,
  output logic [2:0]  WrR_EXMEM
);

  logic [15:0] fwdA, fwdB, opB, aluOut, exResult;
  logic        brHit;
  exCtrl_t     ctrlD, ctrlQ;

  assign fwdA = fwdOperand(Rs1_IDEX, Rd1_IDEX, RegWrite_EXMEM & ~MemtoReg_EXMEM, WrR_EXMEM,
                           ALUO_EXMEM, RegWrite_MEMWB, WrR_MEMWB, WrData_WB);
  assign fwdB = fwdOperand(Rs2_IDEX, Rd2_IDEX, RegWrite_EXMEM & ~MemtoReg_EXMEM, WrR_EXMEM,
                           ALUO_EXMEM, RegWrite_MEMWB, WrR_MEMWB, WrData_WB);
  assign opB  = ALUSrc_IDEX ? Imm_IDEX : fwdB;

  alu16 uAlu (
    .a      (fwdA),
    .b      (opB),
    .op     (ALUOp_IDEX),
    .result (aluOut)
  );

  always_comb begin
    brHit = 1'b0;
    case (BrCond_IDEX)
      BR_BEQZ: brHit = (fwdA == 16'd0);
      BR_BNEZ: brHit = (fwdA != 16'd0);
      BR_BLTZ: brHit = fwdA[15];
      BR_BGEZ: brHit = ~fwdA[15];
      BR_JMP:  brHit = 1'b1;
      default: brHit = 1'b0;
    endcase
  end

  assign takeBranch   = brHit & ~exStall;
  assign branchTarget = PCp2_IDEX + Imm_IDEX;

`ifdef MULT_EN
  localparam int CW = $clog2(MUL_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 2);

  mulState_e   state, stateNext;
  logic [CW-1:0] cnt;
  logic [15:0] mcand, mplier, acc;
  logic        isMul;

  assign isMul = (ALUOp_IDEX == ALU_MUL);

  // The IDLE->BUSY cycle already folds in multiplier bit 0, so BUSY covers the remaining bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MUL_IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else begin
      state <= stateNext;
      case (state)
        MUL_IDLE: begin
          cnt <= '0;
          if (isMul) begin
            acc    <= opB[0] ? fwdA : 16'd0;
            mcand  <= fwdA << 1;
            mplier <= opB >> 1;
          end
        end
        MUL_BUSY: begin
          cnt    <= cnt + CW'(1);
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      MUL_IDLE: if (isMul) stateNext = MUL_BUSY;
      MUL_BUSY: if (cnt == CNT_LAST) stateNext = MUL_DONE;
      MUL_DONE: if (freeze) stateNext = MUL_IDLE;
      default:  stateNext = MUL_IDLE;
    endcase
  end

  assign exStall  = isMul & (state != MUL_DONE);
  assign exResult = (isMul && state == MUL_DONE) ? acc : aluOut;
`else
  assign exStall  = 1'b0;
  assign exResult = aluOut;
`endif

  // A stalled EX slot leaves as a bubble: controls cleared, data fields don't-care.
  assign ctrlD = exStall ? exCtrl_t'('0)
                         : {takeBranch, MemWrite_IDEX, MemRead_IDEX, RegWrite_IDEX,
                            MemtoReg_IDEX, Dump_IDEX, halt_IDEX};

  always_ff @(posedge clk) begin
    if (rst) begin
      ALUO_EXMEM <= '0;
      Rd2_EXMEM  <= '0;
      WrR_EXMEM  <= '0;
      ctrlQ      <= '0;
    end else if (freeze) begin
      ALUO_EXMEM <= exResult;
      Rd2_EXMEM  <= fwdB;
      WrR_EXMEM  <= WrR_IDEX;
      ctrlQ      <= ctrlD;
    end
  end

  assign {takeBranch_EXMEM, MemWrite_EXMEM, MemRead_EXMEM, RegWrite_EXMEM,
          MemtoReg_EXMEM, Dump_EXMEM, halt_EXMEM} = ctrlQ;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage against a behavioural EX/MEM model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst, freeze;
  logic [15:0] Rd1_IDEX, Rd2_IDEX, Imm_IDEX, PCp2_IDEX, WrData_WB;
  logic [2:0]  Rs1_IDEX, Rs2_IDEX, BrCond_IDEX, WrR_IDEX, WrR_MEMWB;
  logic [3:0]  ALUOp_IDEX;
  logic        ALUSrc_IDEX, MemWrite_IDEX, MemRead_IDEX, RegWrite_IDEX, MemtoReg_IDEX;
  logic        Dump_IDEX, halt_IDEX, RegWrite_MEMWB;
  logic        takeBranch, exStall;
  logic [15:0] branchTarget, ALUO_EXMEM, Rd2_EXMEM;
  logic        takeBranch_EXMEM, MemWrite_EXMEM, MemRead_EXMEM, RegWrite_EXMEM;
  logic        MemtoReg_EXMEM, Dump_EXMEM, halt_EXMEM;
  logic [2:0]  WrR_EXMEM;

  int passCnt = 0;
  int totalCnt = 0;

  // Model of the EX/MEM register contents
  logic [15:0] mAluo, mRd2;
  logic [2:0]  mWrR;
  logic        mTb, mMw, mMr, mRw, mMtr, mDump, mHalt;

  logic [41:0] exmemAct, exmemExp;
  logic [6:0]  ctrlAct;
  assign ctrlAct  = {takeBranch_EXMEM, MemWrite_EXMEM, MemRead_EXMEM, RegWrite_EXMEM,
                     MemtoReg_EXMEM, Dump_EXMEM, halt_EXMEM};
  assign exmemAct = {ALUO_EXMEM, Rd2_EXMEM, WrR_EXMEM, ctrlAct};
  assign exmemExp = {mAluo, mRd2, mWrR, mTb, mMw, mMr, mRw, mMtr, mDump, mHalt};

  execute_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .Rd1_IDEX(Rd1_IDEX), .Rd2_IDEX(Rd2_IDEX), .Rs1_IDEX(Rs1_IDEX), .Rs2_IDEX(Rs2_IDEX),
    .Imm_IDEX(Imm_IDEX), .PCp2_IDEX(PCp2_IDEX), .ALUOp_IDEX(ALUOp_IDEX),
    .ALUSrc_IDEX(ALUSrc_IDEX), .BrCond_IDEX(BrCond_IDEX),
    .MemWrite_IDEX(MemWrite_IDEX), .MemRead_IDEX(MemRead_IDEX),
    .RegWrite_IDEX(RegWrite_IDEX), .MemtoReg_IDEX(MemtoReg_IDEX),
    .Dump_IDEX(Dump_IDEX), .halt_IDEX(halt_IDEX), .WrR_IDEX(WrR_IDEX),
    .WrData_WB(WrData_WB), .WrR_MEMWB(WrR_MEMWB), .RegWrite_MEMWB(RegWrite_MEMWB),
    .takeBranch(takeBranch), .branchTarget(branchTarget), .exStall(exStall),
    .ALUO_EXMEM(ALUO_EXMEM), .Rd2_EXMEM(Rd2_EXMEM),
    .takeBranch_EXMEM(takeBranch_EXMEM), .MemWrite_EXMEM(MemWrite_EXMEM),
    .MemRead_EXMEM(MemRead_EXMEM), .RegWrite_EXMEM(RegWrite_EXMEM),
    .MemtoReg_EXMEM(MemtoReg_EXMEM), .Dump_EXMEM(Dump_EXMEM), .halt_EXMEM(halt_EXMEM),
    .WrR_EXMEM(WrR_EXMEM)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] refAlu(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [31:0] w;
    logic [15:0] r;
    int sa, sb, sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b[3:0]);
    r  = '0;
    case (op)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a ^ b;
      4'h3: r = a & ~b;
      4'h4: begin w = {a, a} << sh; r = w[31:16]; end
      4'h5: r = a << sh;
      4'h6: begin w = {a, a} >> sh; r = w[15:0]; end
      4'h7: r = a >> sh;
      4'h8: r = (a == b) ? 16'd1 : 16'd0;
      4'h9: r = (sa < sb) ? 16'd1 : 16'd0;
      4'hA: r = (sa <= sb) ? 16'd1 : 16'd0;
      4'hB: r = ((int'(a) + int'(b)) > 65535) ? 16'd1 : 16'd0;
      4'hC: for (int i = 0; i < 16; i++) r[i] = a[15-i];
      4'hD: r = b;
      4'hE: r = 16'((int'(a) * 256) + (int'(b) % 256));
`ifdef MULT_EN
      4'hF: r = 16'(int'(a) * int'(b));
`else
      4'hF: r = 16'd0;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic refBr(input logic [2:0] c, input logic [15:0] a);
    int sa;
    sa = $signed(a);
    case (c)
      3'd1: return a == 16'd0;
      3'd2: return a != 16'd0;
      3'd3: return sa < 0;
      3'd4: return sa >= 0;
      3'd5: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] refFwd(input logic [2:0] rs, input logic [15:0] v);
    if (mRw && !mMtr && mWrR == rs) return mAluo;
    if (RegWrite_MEMWB && WrR_MEMWB == rs) return WrData_WB;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    mAluo = '0; mRd2 = '0; mWrR = '0;
    {mTb, mMw, mMr, mRw, mMtr, mDump, mHalt} = '0;
  endtask

  // Advance one clock, updating the model as the EX/MEM register should (no stall assumed).
  task automatic step();
    logic [15:0] fa, fb, res;
    logic tb;
    fa  = refFwd(Rs1_IDEX, Rd1_IDEX);
    fb  = refFwd(Rs2_IDEX, Rd2_IDEX);
    res = refAlu(ALUOp_IDEX, fa, ALUSrc_IDEX ? Imm_IDEX : fb);
    tb  = refBr(BrCond_IDEX, fa);
    if (freeze) begin
      mAluo = res; mRd2 = fb; mWrR = WrR_IDEX;
      {mTb, mMw, mMr, mRw, mMtr, mDump, mHalt} =
        {tb, MemWrite_IDEX, MemRead_IDEX, RegWrite_IDEX, MemtoReg_IDEX, Dump_IDEX, halt_IDEX};
    end
    tick();
  endtask

  task automatic clearIdex();
    Rd1_IDEX = '0; Rd2_IDEX = '0; Rs1_IDEX = '0; Rs2_IDEX = '0; Imm_IDEX = '0;
    PCp2_IDEX = '0; ALUOp_IDEX = 4'h0; ALUSrc_IDEX = 0; BrCond_IDEX = '0;
    MemWrite_IDEX = 0; MemRead_IDEX = 0; RegWrite_IDEX = 0; MemtoReg_IDEX = 0;
    Dump_IDEX = 0; halt_IDEX = 0; WrR_IDEX = '0;
    WrData_WB = '0; WrR_MEMWB = '0; RegWrite_MEMWB = 0;
  endtask

  task automatic test_reset();
    clearIdex();
    freeze = 1; rst = 1;
    tick(); tick();
    totalCnt++;
    if (exmemAct !== 42'd0) $display("FAIL reset_exmem: got %h want 0", exmemAct);
    else passCnt++;
    totalCnt++;
    if (exStall !== 1'b0) $display("FAIL reset_stall: got %b want 0", exStall);
    else passCnt++;
    rst = 0;
    modelReset();
  endtask

  task automatic test_add();
    clearIdex();
    Rs1_IDEX = 3'd1; Rd1_IDEX = 16'd5; Rs2_IDEX = 3'd2; Rd2_IDEX = 16'd7;
    RegWrite_IDEX = 1; WrR_IDEX = 3'd6;
    step();
    totalCnt++;
    if (ALUO_EXMEM !== 16'd12 || RegWrite_EXMEM !== 1'b1)
      $display("FAIL add_basic: got aluo=%h rw=%b want aluo=000c rw=1", ALUO_EXMEM, RegWrite_EXMEM);
    else passCnt++;
    totalCnt++;
    if (exmemAct !== exmemExp) $display("FAIL add_model: got %h want %h", exmemAct, exmemExp);
    else passCnt++;
  endtask

  task automatic test_forward();
    clearIdex();
    Rd1_IDEX = 16'h0008; Rd2_IDEX = 16'h0008; Rs1_IDEX = 3'd1; Rs2_IDEX = 3'd2;
    RegWrite_IDEX = 1; WrR_IDEX = 3'd3;
    step();
    // SUB r3 - r4 with both EX/MEM and MEM/WB claiming r3
    clearIdex();
    ALUOp_IDEX = 4'h1; Rs1_IDEX = 3'd3; Rd1_IDEX = 16'h0000; Rs2_IDEX = 3'd4; Rd2_IDEX = 16'h0001;
    RegWrite_MEMWB = 1; WrR_MEMWB = 3'd3; WrData_WB = 16'h5555; WrR_IDEX = 3'd3;
    step();
    totalCnt++;
    if (ALUO_EXMEM !== 16'h000F) $display("FAIL fwd_exmem_priority: got %h want 000f", ALUO_EXMEM);
    else passCnt++;
    // EX/MEM no longer writes: MEM/WB value must reach operand A
    ALUOp_IDEX = 4'h0; ALUSrc_IDEX = 1; Imm_IDEX = 16'h0000;
    step();
    totalCnt++;
    if (ALUO_EXMEM !== 16'h5555) $display("FAIL fwd_memwb: got %h want 5555", ALUO_EXMEM);
    else passCnt++;
    totalCnt++;
    if (exmemAct !== exmemExp) $display("FAIL fwd_model: got %h want %h", exmemAct, exmemExp);
    else passCnt++;
  endtask

  task automatic test_branch();
    clearIdex();
    step();
    BrCond_IDEX = 3'b001; Rs1_IDEX = 3'd5; Rd1_IDEX = 16'h0000;
    PCp2_IDEX = 16'h0040; Imm_IDEX = 16'hFFF8;
    #1;
    totalCnt++;
    if (takeBranch !== 1'b1 || branchTarget !== 16'h0038)
      $display("FAIL beqz_comb: got tb=%b tgt=%h want tb=1 tgt=0038", takeBranch, branchTarget);
    else passCnt++;
    step();
    totalCnt++;
    if (takeBranch_EXMEM !== 1'b1) $display("FAIL beqz_reg: got %b want 1", takeBranch_EXMEM);
    else passCnt++;
    RegWrite_MEMWB = 1; WrR_MEMWB = 3'd5; WrData_WB = 16'h8000;
    #1;
    totalCnt++;
    if (takeBranch !== 1'b0) $display("FAIL beqz_fwd_nz: got %b want 0", takeBranch);
    else passCnt++;
    BrCond_IDEX = 3'b011;
    #1;
    totalCnt++;
    if (takeBranch !== 1'b1) $display("FAIL bltz_fwd: got %b want 1", takeBranch);
    else passCnt++;
    BrCond_IDEX = 3'b100;
    #1;
    totalCnt++;
    if (takeBranch !== 1'b0) $display("FAIL bgez_fwd: got %b want 0", takeBranch);
    else passCnt++;
    step();
  endtask

  task automatic test_freeze();
    clearIdex();
    Rd1_IDEX = 16'h1234; Rd2_IDEX = 16'h0101; RegWrite_IDEX = 1; WrR_IDEX = 3'd7;
    MemWrite_IDEX = 1;
    step();
    freeze = 0;
    for (int i = 0; i < 3; i++) begin
      Rd1_IDEX = 16'($urandom); Rd2_IDEX = 16'($urandom); ALUOp_IDEX = 4'($urandom_range(0, 14));
      WrR_IDEX = 3'($urandom); RegWrite_IDEX = 1'($urandom); MemRead_IDEX = 1'($urandom);
      step();
      totalCnt++;
      if (exmemAct !== exmemExp) $display("FAIL freeze_hold%0d: got %h want %h", i, exmemAct, exmemExp);
      else passCnt++;
    end
    freeze = 1;
    step();
    totalCnt++;
    if (exmemAct !== exmemExp) $display("FAIL freeze_release: got %h want %h", exmemAct, exmemExp);
    else passCnt++;
  endtask

  task automatic test_random();
    logic expTb;
    for (int i = 0; i < 200; i++) begin
      Rd1_IDEX = 16'($urandom); Rd2_IDEX = 16'($urandom); Imm_IDEX = 16'($urandom);
      PCp2_IDEX = 16'($urandom); Rs1_IDEX = 3'($urandom); Rs2_IDEX = 3'($urandom);
`ifdef MULT_EN
      ALUOp_IDEX = 4'($urandom_range(0, 14));
`else
      ALUOp_IDEX = 4'($urandom_range(0, 15));
`endif
      ALUSrc_IDEX = 1'($urandom); BrCond_IDEX = 3'($urandom);
      MemWrite_IDEX = 1'($urandom); MemRead_IDEX = 1'($urandom); RegWrite_IDEX = 1'($urandom);
      MemtoReg_IDEX = ($urandom_range(0, 3) == 0); Dump_IDEX = 1'($urandom);
      halt_IDEX = 1'($urandom); WrR_IDEX = 3'($urandom);
      WrData_WB = 16'($urandom); WrR_MEMWB = 3'($urandom); RegWrite_MEMWB = 1'($urandom);
      freeze = ($urandom_range(0, 3) != 0);
      #1;
      expTb = refBr(BrCond_IDEX, refFwd(Rs1_IDEX, Rd1_IDEX));
      totalCnt++;
      if ({takeBranch, branchTarget} !== {expTb, 16'(PCp2_IDEX + Imm_IDEX)})
        $display("FAIL rand_branch%0d: got %b/%h want %b/%h", i, takeBranch, branchTarget,
                 expTb, 16'(PCp2_IDEX + Imm_IDEX));
      else passCnt++;
      step();
      totalCnt++;
      if (exmemAct !== exmemExp) $display("FAIL rand_exmem%0d: got %h want %h", i, exmemAct, exmemExp);
      else passCnt++;
    end
    freeze = 1;
  endtask

  task automatic test_mul();
    logic [15:0] a, b;
    int stalls;
    clearIdex();
    step();
    for (int k = 0; k < 3; k++) begin
      a = (k == 0) ? 16'h0123 : 16'($urandom);
      b = (k == 0) ? 16'h0010 : 16'($urandom);
      clearIdex();
      ALUOp_IDEX = 4'hF; Rs1_IDEX = 3'd1; Rs2_IDEX = 3'd2; Rd1_IDEX = a; Rd2_IDEX = b;
      RegWrite_IDEX = 1; WrR_IDEX = 3'd4; BrCond_IDEX = 3'b101;
      #1;
`ifdef MULT_EN
      stalls = 0;
      while (exStall === 1'b1 && stalls < 40) begin
        totalCnt++;
        if (takeBranch !== 1'b0) $display("FAIL mul_br_suppress%0d: got %b want 0", k, takeBranch);
        else passCnt++;
        stalls++;
        tick();
        totalCnt++;
        if (ctrlAct !== 7'd0) $display("FAIL mul_bubble%0d: got %b want 0", k, ctrlAct);
        else passCnt++;
      end
      totalCnt++;
      if (stalls != 16) $display("FAIL mul_stall_len%0d: got %0d want 16", k, stalls);
      else passCnt++;
      totalCnt++;
      if (exStall !== 1'b0 || takeBranch !== 1'b1)
        $display("FAIL mul_done%0d: got stall=%b tb=%b want 0/1", k, exStall, takeBranch);
      else passCnt++;
      tick();
      mAluo = 16'(int'(a) * int'(b)); mRd2 = b; mWrR = 3'd4;
      {mTb, mMw, mMr, mRw, mMtr, mDump, mHalt} = 7'b1001000;
`else
      totalCnt++;
      if (exStall !== 1'b0) $display("FAIL mul_nostall%0d: got %b want 0", k, exStall);
      else passCnt++;
      step();
`endif
      totalCnt++;
      if (exmemAct !== exmemExp) $display("FAIL mul_result%0d: got %h want %h", k, exmemAct, exmemExp);
      else passCnt++;
      ALUOp_IDEX = 4'h0; RegWrite_IDEX = 0; BrCond_IDEX = '0;
      step();
    end
  endtask

  task automatic test_reset_mid_mul();
    int stalls;
    clearIdex();
    step();
    ALUOp_IDEX = 4'hF; Rs1_IDEX = 3'd1; Rs2_IDEX = 3'd2; Rd1_IDEX = 16'h00FF; Rd2_IDEX = 16'h0003;
    RegWrite_IDEX = 1; WrR_IDEX = 3'd2;
    for (int i = 0; i < 5; i++) tick();
    rst = 1;
    tick();
    totalCnt++;
    if (exmemAct !== 42'd0) $display("FAIL rst_mid_mul: got %h want 0", exmemAct);
    else passCnt++;
    clearIdex();
    Rs1_IDEX = 3'd1; Rs2_IDEX = 3'd2; Rd1_IDEX = 16'd1; Rd2_IDEX = 16'd1;
    RegWrite_IDEX = 1; WrR_IDEX = 3'd2;
    rst = 0;
    modelReset();
    step();
    totalCnt++;
    if (ALUO_EXMEM !== 16'd2 || RegWrite_EXMEM !== 1'b1)
      $display("FAIL rst_then_add: got aluo=%h rw=%b want 0002/1", ALUO_EXMEM, RegWrite_EXMEM);
    else passCnt++;
`ifdef MULT_EN
    // A fresh multiply must take the full latency after the aborted one
    clearIdex();
    ALUOp_IDEX = 4'hF; Rs1_IDEX = 3'd4; Rs2_IDEX = 3'd5; Rd1_IDEX = 16'd3; Rd2_IDEX = 16'd5;
    RegWrite_IDEX = 1; WrR_IDEX = 3'd1;
    #1;
    stalls = 0;
    while (exStall === 1'b1 && stalls < 40) begin
      stalls++;
      tick();
    end
    totalCnt++;
    if (stalls != 16) $display("FAIL rst_mul_len: got %0d want 16", stalls);
    else passCnt++;
    tick();
    totalCnt++;
    if (ALUO_EXMEM !== 16'd15) $display("FAIL rst_mul_result: got %h want 000f", ALUO_EXMEM);
    else passCnt++;
`endif
  endtask

  initial begin
    rst = 1; freeze = 1;
    clearIdex();
    modelReset();
    test_reset();
    test_add();
    test_forward();
    test_branch();
    test_freeze();
    test_random();
    test_mul();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
